// File: rtl/aes_sbox_arbiter.sv
// Arbitrates one shared S-box ROM between the round datapath (port 0, long bursts)
// and the key expansion (port 1, short bursts), then routes each returned byte to its owner.
module aes_sbox_arbiter #(
    parameter int BURST0  = 16,
    parameter int BURST1  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0,
    input  logic [7:0] addr0,
    output logic       gnt0,
    output logic       rvalid0,
    output logic [7:0] rdata0,
    input  logic       req1,
    input  logic [7:0] addr1,
    output logic       gnt1,
    output logic       rvalid1,
    output logic [7:0] rdata1,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       busy,
    output logic       abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [4:0] LAST0 = 5'(BURST0 - 1);
    localparam logic [4:0] LAST1 = 5'(BURST1 - 1);

    state_t             state_r;
    logic [4:0]         beat_cnt_r;
    logic               last_owner_r;
    logic               busy_r;
    logic               abort_r;
    logic [ROM_LAT-1:0] tag_valid_r;
    logic [ROM_LAT-1:0] tag_owner_r;

    logic       gnt0_s;
    logic       gnt1_s;
    logic [7:0] rom_addr_s;
    logic       own_req_s;
    logic       own_id_s;
    logic       burst_last_s;
    state_t     arb_idle_s;
    state_t     arb_end_s;
    logic       tail_valid_s;
    logic       tail_owner_s;
    logic       rvalid0_s;
    logic       rvalid1_s;
    logic [7:0] rdata0_s;
    logic [7:0] rdata1_s;

    // Ties go to the requester that did not own the previous burst.
    function automatic state_t arbitrate(input logic r0, input logic r1, input logic last_owner);
        state_t winner;
        if (r0 && r1) begin
            winner = last_owner ? OWN0 : OWN1;
        end else if (r0) begin
            winner = OWN0;
        end else if (r1) begin
            winner = OWN1;
        end else begin
            winner = IDLE;
        end
        return winner;
    endfunction

    // Grant, ROM address mux and current-owner decode.
    always_comb begin
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        rom_addr_s   = 8'h00;
        own_req_s    = 1'b0;
        own_id_s     = 1'b0;
        burst_last_s = 1'b0;
        case (state_r)
            OWN0: begin
                gnt0_s       = req0;
                rom_addr_s   = addr0;
                own_req_s    = req0;
                own_id_s     = 1'b0;
                burst_last_s = (beat_cnt_r == LAST0);
            end
            OWN1: begin
                gnt1_s       = req1;
                rom_addr_s   = addr1;
                own_req_s    = req1;
                own_id_s     = 1'b1;
                burst_last_s = (beat_cnt_r == LAST1);
            end
            default: begin
                gnt0_s     = 1'b0;
                gnt1_s     = 1'b0;
                rom_addr_s = 8'h00;
            end
        endcase
        arb_idle_s = arbitrate(req0, req1, last_owner_r);
        arb_end_s  = arbitrate(req0, req1, own_id_s);
    end

    // Ownership FSM: burst locking, beat counting, round-robin handover and abort detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            beat_cnt_r   <= 5'd0;
            last_owner_r <= 1'b1;
            busy_r       <= 1'b0;
            abort_r      <= 1'b0;
        end else begin
            abort_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r    <= arb_idle_s;
                    busy_r     <= (arb_idle_s != IDLE);
                    beat_cnt_r <= 5'd0;
                end
                OWN0, OWN1: begin
                    if (own_req_s) begin
                        if (burst_last_s) begin
                            beat_cnt_r   <= 5'd0;
                            last_owner_r <= own_id_s;
                            state_r      <= arb_end_s;
                            busy_r       <= (arb_end_s != IDLE);
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 5'd1;
                        end
                    end else begin
                        // A dropped req after at least one beat is an abort; before any beat it is a quiet release.
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        beat_cnt_r <= 5'd0;
                        if (beat_cnt_r != 5'd0) begin
                            abort_r      <= 1'b1;
                            last_owner_r <= own_id_s;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    beat_cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Tag pipeline tracks which owner each in-flight ROM read belongs to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_valid_r <= '0;
            tag_owner_r <= '0;
        end else begin
            tag_valid_r[0] <= gnt0_s | gnt1_s;
            tag_owner_r[0] <= gnt1_s;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_owner_r[i] <= tag_owner_r[i-1];
            end
        end
    end

    // Return routing: only the owning port sees ROM data, the other stays at zero.
    always_comb begin
        tail_valid_s = tag_valid_r[ROM_LAT-1];
        tail_owner_s = tag_owner_r[ROM_LAT-1];
        rvalid0_s    = tail_valid_s & ~tail_owner_s;
        rvalid1_s    = tail_valid_s & tail_owner_s;
        if (rvalid0_s) begin
            rdata0_s = rom_data;
        end else begin
            rdata0_s = 8'h00;
        end
        if (rvalid1_s) begin
            rdata1_s = rom_data;
        end else begin
            rdata1_s = 8'h00;
        end
    end

    assign gnt0     = gnt0_s;
    assign gnt1     = gnt1_s;
    assign rom_addr = rom_addr_s;
    assign rvalid0  = rvalid0_s;
    assign rvalid1  = rvalid1_s;
    assign rdata0   = rdata0_s;
    assign rdata1   = rdata1_s;
    assign busy     = busy_r;
    assign abort    = abort_r;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Bench for aes_sbox_arbiter: two instances (ROM_LAT 1 and 2) share the same stimulus table;
// returned bytes are checked against a per-port, per-latency scoreboard.
module tb_aes_sbox_arbiter;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef struct {
        logic       r0;
        logic [7:0] a0;
        logic       r1;
        logic [7:0] a1;
        logic       g0;
        logic       g1;
        logic       bsy;
        logic       abt;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } sb_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] addr0 = 8'h00;
    logic [7:0] addr1 = 8'h00;

    logic       gnt0_1, gnt1_1, rvalid0_1, rvalid1_1, busy_1, abort_1;
    logic [7:0] rdata0_1, rdata1_1, rom_addr_1, rom_data_1;
    logic       gnt0_2, gnt1_2, rvalid0_2, rvalid1_2, busy_2, abort_2;
    logic [7:0] rdata0_2, rdata1_2, rom_addr_2, rom_data_2, rom_pipe_2;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    vec_t tab[$];
    sb_t  sbq[4][$];
    logic rv [4];
    logic [7:0] rd [4];

    aes_sbox_arbiter #(.BURST0(16), .BURST1(4), .ROM_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn),
        .req0(req0), .addr0(addr0), .gnt0(gnt0_1), .rvalid0(rvalid0_1), .rdata0(rdata0_1),
        .req1(req1), .addr1(addr1), .gnt1(gnt1_1), .rvalid1(rvalid1_1), .rdata1(rdata1_1),
        .rom_addr(rom_addr_1), .rom_data(rom_data_1), .busy(busy_1), .abort(abort_1)
    );

    aes_sbox_arbiter #(.BURST0(16), .BURST1(4), .ROM_LAT(2)) dut2 (
        .clk(clk), .resetn(resetn),
        .req0(req0), .addr0(addr0), .gnt0(gnt0_2), .rvalid0(rvalid0_2), .rdata0(rdata0_2),
        .req1(req1), .addr1(addr1), .gnt1(gnt1_2), .rvalid1(rvalid1_2), .rdata1(rdata1_2),
        .rom_addr(rom_addr_2), .rom_data(rom_data_2), .busy(busy_2), .abort(abort_2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM models with one and two cycles of read latency.
    always @(posedge clk) rom_data_1 <= SBOX[rom_addr_1];
    always @(posedge clk) begin
        rom_pipe_2 <= SBOX[rom_addr_2];
        rom_data_2 <= rom_pipe_2;
    end

    always_comb begin
        rv[0] = rvalid0_1; rv[1] = rvalid1_1; rv[2] = rvalid0_2; rv[3] = rvalid1_2;
        rd[0] = rdata0_1;  rd[1] = rdata1_1;  rd[2] = rdata0_2;  rd[3] = rdata1_2;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %02h, expected %02h", name, cyc, act, exp);
        end
    endtask

    function automatic void add(input logic r0, input logic [7:0] a0, input logic r1,
                                input logic [7:0] a1, input logic g0, input logic g1,
                                input logic bsy, input logic abt);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.g0 = g0; v.g1 = g1; v.bsy = bsy; v.abt = abt;
        tab.push_back(v);
    endfunction

    task automatic push_sb(input int port, input logic [7:0] a);
        sb_t e;
        e.data = SBOX[a];
        e.due  = cyc + 1;
        sbq[port].push_back(e);
        e.due  = cyc + 2;
        sbq[2 + port].push_back(e);
    endtask

    task automatic apply_vec(input vec_t v);
        @(posedge clk);
        #1;
        req0 = v.r0; addr0 = v.a0; req1 = v.r1; addr1 = v.a1;
        @(negedge clk);
        chk1("gnt0_lat1", gnt0_1, v.g0);
        chk1("gnt1_lat1", gnt1_1, v.g1);
        chk1("gnt0_lat2", gnt0_2, v.g0);
        chk1("gnt1_lat2", gnt1_2, v.g1);
        chk1("busy", busy_1, v.bsy);
        chk1("abort", abort_1, v.abt);
        chk1("busy_lat2", busy_2, v.bsy);
        chk1("abort_lat2", abort_2, v.abt);
        if (v.g0) begin
            chk8("rom_addr_p0", rom_addr_1, v.a0);
            push_sb(0, v.a0);
        end
        if (v.g1) begin
            chk8("rom_addr_p1", rom_addr_1, v.a1);
            push_sb(1, v.a1);
        end
        if (!v.bsy) begin
            chk8("rom_addr_idle", rom_addr_1, 8'h00);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_gnt0"}, gnt0_1, 1'b0);     chk1({tag, "_gnt1"}, gnt1_1, 1'b0);
        chk1({tag, "_rvalid0"}, rvalid0_1, 1'b0); chk1({tag, "_rvalid1"}, rvalid1_1, 1'b0);
        chk8({tag, "_rdata0"}, rdata0_1, 8'h00); chk8({tag, "_rdata1"}, rdata1_1, 8'h00);
        chk8({tag, "_rom_addr"}, rom_addr_1, 8'h00);
        chk1({tag, "_busy"}, busy_1, 1'b0);     chk1({tag, "_abort"}, abort_1, 1'b0);
        chk1({tag, "_gnt0_l2"}, gnt0_2, 1'b0);  chk1({tag, "_rvalid0_l2"}, rvalid0_2, 1'b0);
        chk1({tag, "_rvalid1_l2"}, rvalid1_2, 1'b0);
        chk8({tag, "_rdata0_l2"}, rdata0_2, 8'h00);
        chk1({tag, "_busy_l2"}, busy_2, 1'b0);
    endtask

    // Return-path scoreboard: each stream must show exactly the expected byte on its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < 4; s++) begin
                if (sbq[s].size() > 0 && sbq[s][0].due == cyc) begin
                    chk1($sformatf("rvalid_s%0d", s), rv[s], 1'b1);
                    chk8($sformatf("rdata_s%0d", s), rd[s], sbq[s][0].data);
                    void'(sbq[s].pop_front());
                end else begin
                    chk1($sformatf("rvalid_s%0d", s), rv[s], 1'b0);
                    chk8($sformatf("rdata_idle_s%0d", s), rd[s], 8'h00);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pa [16];
        logic [7:0] ka [4];
        int         end_a;

        pa[0] = 8'h00; pa[1] = 8'h01; pa[2] = 8'h53; pa[3] = 8'hFF;
        for (int i = 4; i < 16; i++) pa[i] = 8'(i * 37);
        ka[0] = 8'h09; ka[1] = 8'hCF; ka[2] = 8'h4F; ka[3] = 8'h3C;

        // Single port-0 burst, then release (final beat with req0 alone re-enters OWN0 unstarted).
        add(1'b1, pa[0], 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) add(1'b1, pa[i], 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end_a = tab.size();

        // Contention right after reset: port 0 wins the tie, port 1 follows with no gap.
        add(1'b1, pa[0], 1'b1, ka[0], 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) add(1'b1, pa[i], 1'b1, ka[0], 1'b1, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) add(1'b0, 8'h00, 1'b1, ka[j], 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Both held continuously: owners alternate 0, 1, 0, 1, then a third OWN0 never starts.
        add(1'b1, pa[0], 1'b1, ka[0], 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) add(1'b1, pa[i], 1'b1, ka[0], 1'b1, 1'b0, 1'b1, 1'b0);
            for (int j = 0; j < 4; j++) add(1'b1, pa[0], 1'b1, ka[j], 1'b0, 1'b1, 1'b1, 1'b0);
        end
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Key burst on port 1 alone.
        add(1'b0, 8'h00, 1'b1, ka[0], 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) add(1'b0, 8'h00, 1'b1, ka[j], 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort after 5 beats with port 1 pending.
        add(1'b1, pa[0], 1'b1, ka[0], 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b1, pa[i], 1'b1, ka[0], 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, ka[0], 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, ka[0], 1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) add(1'b0, 8'h00, 1'b1, ka[j], 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Power-on reset.
        #2;
        resetn = 1'b0;
        #1;
        chk_quiet("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < end_a; i++) apply_vec(tab[i]);

        // Reset at beat 8 of a port-0 burst: outputs drop at once, in-flight beats vanish.
        begin
            vec_t v;
            v.r0 = 1'b1; v.a0 = 8'h20; v.r1 = 1'b0; v.a1 = 8'h00;
            v.g0 = 1'b0; v.g1 = 1'b0; v.bsy = 1'b0; v.abt = 1'b0;
            apply_vec(v);
            for (int i = 0; i < 8; i++) begin
                v.a0 = 8'(8'h20 + i); v.g0 = 1'b1; v.bsy = 1'b1;
                apply_vec(v);
            end
        end
        #1;
        resetn = 1'b0;
        mon_en = 1'b0;
        for (int s = 0; s < 4; s++) sbq[s].delete();
        #1;
        chk_quiet("midrst");
        req0 = 1'b0;
        addr0 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        for (int i = end_a; i < tab.size(); i++) apply_vec(tab[i]);

        @(negedge clk);
        for (int s = 0; s < 4; s++) chk8($sformatf("sb_empty_s%0d", s), 8'(sbq[s].size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_sbox_arbiter.md
# aes_sbox_arbiter

Shares one 256-entry S-box ROM (1-cycle registered read, as used by the encryption core) between two requesters: port 0, the round datapath, which issues 16-byte SubBytes bursts; and port 1, the on-the-fly key expansion, which issues 4-byte SubWord bursts. Ownership is locked for a whole burst. Arbitration is round-robin at burst boundaries. Each returned byte is routed to its owner with a fixed, known latency. The block sits between the encryption FSM/key scheduler and the S-box ROM instance.

## Interface
- BURST0, 16: beats per burst, requester 0 (round datapath)
- BURST1, 4: beats per burst, requester 1 (key expansion)
- ROM_LAT, 1: S-box ROM read latency in cycles (must be ≥1)
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req0  in  1  requester 0 wants a lookup this cycle
- addr0  in  8  requester 0 S-box index
- gnt0  out  1  requester 0 beat accepted this cycle
- rvalid0  out  1  rdata0 valid
- rdata0  out  8  S-box result for requester 0
- req1, addr1, gnt1, rvalid1, rdata1: same as above, for requester 1
- rom_addr  out  8  address to S-box ROM
- rom_data  in  8  ROM output, valid ROM_LAT cycles after rom_addr
- busy  out  1  a burst owner exists (state ≠ IDLE)
- abort  out  1  one-cycle pulse: owner dropped req mid-burst

## Operation
- FSM states: IDLE, OWN0, OWN1. State is registered.
- Arbitration function, evaluated in IDLE and on the final beat of a burst:
  - If only one req is high, that requester wins.
  - If both are high, the requester ≠ last_owner wins.
  - If neither is high, next state is IDLE.
- last_owner is 1 after reset, so requester 0 wins the first tie.
- IDLE: gnt0 = gnt1 = 0. The next state is the arbitration winner, entered at the next edge. Decision costs one cycle.
- OWNx:
  - gntx = reqx, combinationally. The other gnt is 0.
  - rom_addr = addrx. In IDLE, rom_addr = 0.
  - beat_cnt (5 bits) increments on each gntx.
- Burst end (gntx high and beat_cnt = BURSTx−1):
  - beat_cnt clears to 0 and last_owner is set to x.
  - Next state comes from arbitration, so a back-to-back handover needs no IDLE cycle.
- Abort (reqx low in OWNx with beat_cnt ≠ 0):
  - Next state is IDLE and beat_cnt clears.
  - abort pulses high in the following cycle.
  - last_owner is set to x.
  - Already-issued beats still return.
- reqx low in OWNx with beat_cnt = 0 (owner never started): return to IDLE, no abort pulse.
- Return path:
  - A tag pipeline of ROM_LAT stages holds {valid, owner}, loaded with {gnt0|gnt1, gnt1}.
  - At the tail of the pipeline, rvalidx = valid & (owner == x) and rdatax = rom_data.
  - The unselected rdata is held at 0.
- Widths: beat_cnt saturates nowhere; BURSTx must be ≤ 31.

## Timing
- Reset values: gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0x00, rom_addr = 0x00, busy = 0, abort = 0. State is IDLE, beat_cnt = 0, last_owner = 1, tag pipeline cleared.
- Asserting resetn low mid-burst:
  - All of the above takes effect immediately.
  - In-flight tags are discarded, so no rvalid is issued for beats accepted before reset.
- Grant latency: req rising in IDLE gives gnt in the next cycle.
- Beat acceptance: a beat is accepted in cycle k if gntx = 1. rvalidx and the data are presented in cycle k+ROM_LAT.
- Throughput:
  - One beat per cycle while the owner holds req.
  - A full BURST0 burst occupies 16 consecutive cycles if unbroken.
  - A bubble (reqx low for one cycle) is treated as an abort, not a stall.
- Handover: final beat of owner x in cycle k, other requester waiting → gnt of the other requester in cycle k+1.
- Simultaneous first requests: both req rise in the same cycle from reset → OWN0 first, then OWN1.
- busy equals (state ≠ IDLE) registered; it is high during OWNx including the final beat cycle.

## Test plan
- Single burst, ROM_LAT=1:
  - Stimulus: req0 with addr0 = 0x00, 0x01, 0x53, 0xFF, … for 16 beats.
  - Required: gnt0 from cycle 1 for 16 cycles; rvalid0 one cycle after each gnt with rdata0 = 0x63, 0x7C, 0xED, 0x16, …; gnt1 never high; busy drops after the last beat.
- Contention:
  - Stimulus: req0 and req1 rise together.
  - Required: 16 gnt0 beats, then gnt1 in the very next cycle for 4 beats, with no IDLE gap.
  - Repeat with both held continuously: owners alternate 0, 1, 0, 1.
- Key burst:
  - Stimulus: req1 alone, addr1 = 0x09, 0xCF, 0x4F, 0x3C.
  - Required: rdata1 = 0x01, 0x8A, 0x84, 0xEB; rvalid0 stays 0 throughout.
- Abort:
  - Stimulus: req0 dropped after beat 5.
  - Required: abort pulses once; all 5 results still return on rvalid0; a pending req1 is granted within 2 cycles.
- Reset mid-burst:
  - Stimulus: resetn low at beat 8 of a requester 0 burst.
  - Required: all outputs 0 immediately; no rvalid after release; the next tie is won by requester 0.
- Latency parameter:
  - Stimulus: ROM_LAT = 2, using a 2-cycle ROM model.
  - Required: each rvalid arrives 2 cycles after its gnt, with correct owner routing across a handover.
